// File: rtl/button_conditioner.sv
// Push-button input stage: sync, tick-based debounce, edge pulses
// and optional auto-repeat per button.
module button_conditioner #(
  parameter int N_BTN = 4,
  parameter int TICK_DIV = 50000,
  parameter int DEB_TICKS = 20,
  parameter int RPT_DELAY = 300,
  parameter int RPT_RATE = 80,
  parameter logic [N_BTN-1:0] REPEAT_MASK = 4'b0011,
  parameter bit ACTIVE_HIGH = 1'b1
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_act,
  output logic             tick
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DEB_TICKS + 1);
  localparam int HMAX = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
  localparam int HW = $clog2(HMAX + 1);

  localparam logic [TW-1:0] T_END = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] D_ACC = DW'(DEB_TICKS);
  localparam logic [HW-1:0] H_DLY = HW'(RPT_DELAY);
  localparam logic [HW-1:0] H_RATE = HW'(RPT_RATE);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rpt_state_t;

  logic [TW-1:0]    tick_cnt;
  logic [N_BTN-1:0] sync_a;
  logic [N_BTN-1:0] sync_b;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
    end else if (tick_cnt == T_END) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign tick = (tick_cnt == T_END);

  // Polarity is folded in after the first flop so sync_b is 1 = pressed.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= btn_raw;
      sync_b <= ACTIVE_HIGH ? sync_a : ~sync_a;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    logic [DW-1:0] deb_cnt;
    logic [DW-1:0] deb_nxt;
    logic          lvl;
    logic          lvl_q;
    logic          prs;
    logic          rel;
    rpt_state_t    st;
    logic [HW-1:0] hold;
    logic [HW-1:0] hold_nxt;
    logic          rpt;
    logic          act;

    assign deb_nxt = deb_cnt + 1'b1;
    assign hold_nxt = hold + 1'b1;

    always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
        deb_cnt <= '0;
        lvl <= 1'b0;
      end else if (sync_b[i] == lvl) begin
        deb_cnt <= '0;
      end else if (tick) begin
        if (deb_nxt == D_ACC) begin
          lvl <= sync_b[i];
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_nxt;
        end
      end
    end

    always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
        lvl_q <= 1'b0;
        prs <= 1'b0;
        rel <= 1'b0;
      end else begin
        lvl_q <= lvl;
        prs <= lvl & ~lvl_q;
        rel <= ~lvl & lvl_q;
      end
    end

    // A dropped level aborts any pending repeat in the same cycle.
    always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
        st <= IDLE;
        hold <= '0;
        rpt <= 1'b0;
        act <= 1'b0;
      end else begin
        rpt <= 1'b0;
        act <= prs | rpt;
        if (!REPEAT_MASK[i] || !lvl) begin
          st <= IDLE;
          hold <= '0;
        end else begin
          unique case (st)
            IDLE: begin
              if (prs) begin
                st <= DELAY;
                hold <= '0;
              end
            end
            DELAY: begin
              if (tick) begin
                if (hold_nxt == H_DLY) begin
                  rpt <= 1'b1;
                  hold <= '0;
                  st <= REPEAT;
                end else begin
                  hold <= hold_nxt;
                end
              end
            end
            REPEAT: begin
              if (tick) begin
                if (hold_nxt == H_RATE) begin
                  rpt <= 1'b1;
                  hold <= '0;
                end else begin
                  hold <= hold_nxt;
                end
              end
            end
            default: begin
              st <= IDLE;
              hold <= '0;
            end
          endcase
        end
      end
    end

    assign btn_level[i] = lvl;
    assign btn_press[i] = prs;
    assign btn_release[i] = rel;
    assign btn_act[i] = act;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: vector table plus
// hand-written reset sequence, active-high and active-low builds.
module tb_button_conditioner;

  logic       CLK = 1'b0;
  logic       reset;
  logic [3:0] btn_raw;
  logic [3:0] raw_n;
  logic [3:0] lvl, prs, rel, act;
  logic [3:0] n_lvl, n_prs, n_rel, n_act;
  logic       tick, n_tick;

  assign raw_n = ~btn_raw;

  always #5 CLK = ~CLK;

  button_conditioner #(
    .N_BTN(4), .TICK_DIV(4), .DEB_TICKS(3),
    .RPT_DELAY(5), .RPT_RATE(2),
    .REPEAT_MASK(4'b0011), .ACTIVE_HIGH(1'b1)
  ) dut (
    .CLK(CLK), .reset(reset), .btn_raw(btn_raw),
    .btn_level(lvl), .btn_press(prs),
    .btn_release(rel), .btn_act(act), .tick(tick)
  );

  button_conditioner #(
    .N_BTN(4), .TICK_DIV(4), .DEB_TICKS(3),
    .RPT_DELAY(5), .RPT_RATE(2),
    .REPEAT_MASK(4'b0011), .ACTIVE_HIGH(1'b0)
  ) dut_n (
    .CLK(CLK), .reset(reset), .btn_raw(raw_n),
    .btn_level(n_lvl), .btn_press(n_prs),
    .btn_release(n_rel), .btn_act(n_act), .tick(n_tick)
  );

  typedef struct {
    logic [3:0]  raw;
    int          cyc;
    bit          aln;
    logic [3:0]  lvl;
    logic [15:0] np;
    logic [15:0] nr;
    logic [15:0] na;
    int          fb;
    int          t_lvl;
    int          t_prs;
    int          t_a1;
    int          t_a2;
  } vec_t;

  vec_t tbl[$];

  int checks, errors;
  int k, tk, ft, ntk, viol;
  int fl[4], fp[4], a1[4], a2[4], nfl[4];
  logic [15:0] c_p, c_r, c_a, n_p, n_r, n_a;

  function automatic vec_t mk(
    logic [3:0] raw, int cyc, bit aln, logic [3:0] lv,
    logic [15:0] np, logic [15:0] nr, logic [15:0] na,
    int fb, int tl, int tp, int ta1, int ta2);
    vec_t v;
    v.raw = raw; v.cyc = cyc; v.aln = aln; v.lvl = lv;
    v.np = np; v.nr = nr; v.na = na; v.fb = fb;
    v.t_lvl = tl; v.t_prs = tp; v.t_a1 = ta1; v.t_a2 = ta2;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    k++;
    if (tick) begin
      tk++;
      if (ft == 0) ft = k;
    end
    if (n_tick) ntk++;
    if ((prs & rel) != 0 || (n_prs & n_rel) != 0) viol++;
    for (int i = 0; i < 4; i++) begin
      if (lvl[i] && fl[i] == 0) fl[i] = k;
      if (prs[i]) begin
        c_p[i*4 +: 4] = c_p[i*4 +: 4] + 4'd1;
        if (fp[i] == 0) fp[i] = k;
      end
      if (rel[i]) c_r[i*4 +: 4] = c_r[i*4 +: 4] + 4'd1;
      if (act[i]) begin
        c_a[i*4 +: 4] = c_a[i*4 +: 4] + 4'd1;
        if (a1[i] == 0) a1[i] = k;
        else if (a2[i] == 0) a2[i] = k;
      end
      if (n_lvl[i] && nfl[i] == 0) nfl[i] = k;
      if (n_prs[i]) n_p[i*4 +: 4] = n_p[i*4 +: 4] + 4'd1;
      if (n_rel[i]) n_r[i*4 +: 4] = n_r[i*4 +: 4] + 4'd1;
      if (n_act[i]) n_a[i*4 +: 4] = n_a[i*4 +: 4] + 4'd1;
    end
  endtask

  task automatic run(input logic [3:0] raw, input int cyc);
    btn_raw = raw;
    k = 0; tk = 0; ft = 0; ntk = 0;
    c_p = '0; c_r = '0; c_a = '0;
    n_p = '0; n_r = '0; n_a = '0;
    for (int i = 0; i < 4; i++) begin
      fl[i] = 0; fp[i] = 0; a1[i] = 0; a2[i] = 0; nfl[i] = 0;
    end
    repeat (cyc) step();
  endtask

  // Leaves the bench where the next clock edge is a tick edge.
  task automatic align();
    int g;
    g = 0;
    while (tick !== 1'b1 && g < 8) begin
      step();
      g++;
    end
    chk("align_tick", {31'd0, tick}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    checks = 0; errors = 0; viol = 0;
    reset = 1'b0;
    btn_raw = 4'h0;

    tbl.push_back(mk(4'h4, 40, 1, 4'h4, 16'h0100, 16'h0, 16'h0100,
                     2, 13, 14, 15, 0));
    tbl.push_back(mk(4'h0, 40, 1, 4'h0, 16'h0, 16'h0100, 16'h0,
                     -1, 0, 0, 0, 0));
    for (int b = 0; b < 10; b++) begin
      tbl.push_back(mk((b % 2 == 0) ? 4'h1 : 4'h0, 3, 0, 4'h0,
                       16'h0, 16'h0, 16'h0, -1, 0, 0, 0, 0));
    end
    tbl.push_back(mk(4'h0, 20, 1, 4'h0, 16'h0, 16'h0, 16'h0,
                     0, 0, 0, 0, 0));
    tbl.push_back(mk(4'h2, 64, 1, 4'h2, 16'h0010, 16'h0, 16'h0050,
                     1, 13, 14, 15, 34));
    tbl.push_back(mk(4'h0, 40, 1, 4'h0, 16'h0, 16'h0010, 16'h0020,
                     -1, 0, 0, 0, 0));
    tbl.push_back(mk(4'h3, 64, 1, 4'h3, 16'h0011, 16'h0, 16'h0055,
                     0, 13, 14, 15, 34));
    tbl.push_back(mk(4'h0, 40, 1, 4'h0, 16'h0, 16'h0011, 16'h0022,
                     -1, 0, 0, 0, 0));

    #22;
    chk("rst_lvl", {28'd0, lvl}, 32'd0);
    chk("rst_prs", {28'd0, prs}, 32'd0);
    chk("rst_rel", {28'd0, rel}, 32'd0);
    chk("rst_act", {28'd0, act}, 32'd0);
    chk("rst_tick", {31'd0, tick}, 32'd0);
    chk("rst_n_lvl", {28'd0, n_lvl}, 32'd0);

    @(negedge CLK);
    reset = 1'b1;
    run(4'h0, 12);
    chk("tick_first", ft, 3);
    chk("tick_count", tk, 3);
    chk("n_tick_count", ntk, 3);

    for (int r = 0; r < tbl.size(); r++) begin
      v = tbl[r];
      if (v.aln) align();
      run(v.raw, v.cyc);
      chk($sformatf("r%0d_lvl", r), {28'd0, lvl}, {28'd0, v.lvl});
      chk($sformatf("r%0d_prs_cnt", r), {16'd0, c_p}, {16'd0, v.np});
      chk($sformatf("r%0d_rel_cnt", r), {16'd0, c_r}, {16'd0, v.nr});
      chk($sformatf("r%0d_act_cnt", r), {16'd0, c_a}, {16'd0, v.na});
      chk($sformatf("r%0d_n_lvl", r), {28'd0, n_lvl}, {28'd0, v.lvl});
      chk($sformatf("r%0d_n_prs_cnt", r), {16'd0, n_p}, {16'd0, v.np});
      chk($sformatf("r%0d_n_rel_cnt", r), {16'd0, n_r}, {16'd0, v.nr});
      chk($sformatf("r%0d_n_act_cnt", r), {16'd0, n_a}, {16'd0, v.na});
      if (v.fb >= 0 && v.t_lvl > 0) begin
        chk($sformatf("r%0d_lvl_t", r), fl[v.fb], v.t_lvl);
        chk($sformatf("r%0d_prs_t", r), fp[v.fb], v.t_prs);
        chk($sformatf("r%0d_act1_t", r), a1[v.fb], v.t_a1);
        chk($sformatf("r%0d_act2_t", r), a2[v.fb], v.t_a2);
        chk($sformatf("r%0d_n_lvl_t", r), nfl[v.fb], v.t_lvl);
      end
    end

    align();
    run(4'h2, 40);
    chk("s4_pre_lvl", {31'd0, lvl[1]}, 32'd1);
    chk("s4_pre_act_cnt", {16'd0, c_a}, 32'h0020);
    #3;
    reset = 1'b0;
    #1;
    chk("s4_rst_lvl", {28'd0, lvl}, 32'd0);
    chk("s4_rst_prs", {28'd0, prs}, 32'd0);
    chk("s4_rst_rel", {28'd0, rel}, 32'd0);
    chk("s4_rst_act", {28'd0, act}, 32'd0);
    chk("s4_rst_tick", {31'd0, tick}, 32'd0);
    chk("s4_rst_n_lvl", {28'd0, n_lvl}, 32'd0);
    repeat (3) @(posedge CLK);
    #1;
    chk("s4_held_lvl", {28'd0, lvl}, 32'd0);
    @(negedge CLK);
    #2;
    reset = 1'b1;
    run(4'h2, 40);
    chk("s4_lvl_t", fl[1], 12);
    chk("s4_prs_t", fp[1], 13);
    chk("s4_act1_t", a1[1], 14);
    chk("s4_act2_t", a2[1], 33);
    chk("s4_rel_cnt", {16'd0, c_r}, 32'd0);
    chk("s4_n_lvl_t", nfl[1], 12);
    run(4'h0, 40);
    chk("s4_end_lvl", {28'd0, lvl}, 32'd0);
    chk("s4_end_rel", {16'd0, c_r}, 32'h0010);

    chk("prs_rel_overlap", viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Upstream input stage for the 8x8 LED paddle game. Conditions the raw push-button inputs (left, right, throw, game reset) before the game-logic stage consumes them.
- Per button: synchronises the raw input to CLK, debounces it on a millisecond tick, and produces a clean level plus one-CLK-cycle press/release pulses.
- Buttons selected by REPEAT_MASK also produce auto-repeat pulses while held, so the paddle keeps moving.
- The game stage samples only pulses and no longer needs its own button clock divider.

Parameters:
- N_BTN, 4: number of buttons. Bit order: 0=left, 1=right, 2=throw, 3=game reset.
- TICK_DIV, 50000: CLK cycles per debounce/repeat tick (1 ms at 50 MHz).
- DEB_TICKS, 20: consecutive ticks a changed input must hold before it is accepted.
- RPT_DELAY, 300: ticks from press pulse to first repeat pulse.
- RPT_RATE, 80: ticks between subsequent repeat pulses.
- REPEAT_MASK, 4'b0011: per-button auto-repeat enable (left, right only).
- ACTIVE_HIGH, 1: 1 means a pressed button reads 1 on btn_raw; 0 means the input is inverted at the input.

Ports:
- CLK  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- btn_raw  in  N_BTN  raw asynchronous button pins
- btn_level  out  N_BTN  debounced pressed state, 1 = pressed
- btn_press  out  N_BTN  one-cycle pulse on accepted press
- btn_release  out  N_BTN  one-cycle pulse on accepted release
- btn_act  out  N_BTN  btn_press OR auto-repeat pulse; this is the game-logic command input
- tick  out  1  one-cycle pulse every TICK_DIV cycles, shared with the game stage

Behaviour:
Reset (reset=0, asynchronous):
- All synchroniser flops, counters and outputs go to 0.
- A button physically held through reset is treated as released; it is accepted as a press only after full debounce once reset deasserts.

Tick generator:
- Free-running counter 0..TICK_DIV-1, width clog2(TICK_DIV).
- tick=1 for exactly the one cycle where count==TICK_DIV-1, then wraps to 0.

Synchroniser:
- 2-flop per bit; apply polarity after the first flop.
- sync[i] lags btn_raw by 2 cycles.

Debounce, per button, counter width clog2(DEB_TICKS+1):
- sync==btn_level: counter cleared every cycle.
- sync!=btn_level and tick: counter +1.
- Counter reaching DEB_TICKS (on that tick cycle): btn_level <= sync and counter clears in the same cycle.
- Any bounce back to match before DEB_TICKS clears the counter; no output change.

Edge pulses:
- btn_press = level rose this cycle (registered, 1 cycle wide, the cycle after btn_level goes high).
- btn_release likewise on the falling edge.
- Press and release of one button can never assert in the same cycle.

Auto-repeat, per button with REPEAT_MASK[i]=1, state machine IDLE -> DELAY -> REPEAT:
- IDLE: btn_press moves to DELAY with hold counter=0.
- DELAY: +1 per tick. At RPT_DELAY, emit a repeat pulse, clear the counter, go to REPEAT.
- REPEAT: +1 per tick. At RPT_RATE, emit a repeat pulse and clear the counter.
- btn_level=0 in any state: return to IDLE immediately; no pulse that cycle.
- Hold counter width clog2(max(RPT_DELAY,RPT_RATE)+1).
- Buttons with mask=0 stay in IDLE.

btn_act:
- btn_act[i] = btn_press[i] | repeat_pulse[i], registered, 1 cycle.
- Press and repeat cannot coincide.

Simultaneous buttons:
- Fully independent channels; any combination may pulse in the same cycle.
- Left and right held together both repeat; resolving the conflict is the game stage's job.

Sizing and timing:
- No combinational path from btn_raw to any output.
- Reset mid-operation aborts all state; no pulse is emitted on reset exit.

Test Plan:
Bench parameters: TICK_DIV=4, DEB_TICKS=3, RPT_DELAY=5, RPT_RATE=2, REPEAT_MASK=4'b0011.
1. Clean press of btn_raw[2], held 40 cycles:
   - btn_level[2] rises within 2+4*4=18 cycles.
   - Exactly one btn_press[2] and one btn_act[2] pulse, 1 cycle each.
   - No repeats (mask=0).
2. Bounce: btn_raw[0] toggles 1/0 every 3 cycles for 30 cycles, then stays 0:
   - btn_level[0] never rises.
   - No press/act pulses.
3. Auto-repeat: btn_raw[1] held 60 cycles:
   - btn_press at T.
   - Repeat btn_act pulses at T+~20 cycles (5 ticks), then every 8 cycles (2 ticks), pulse count matching the hold length.
   - One btn_release after the input drops, following debounce.
4. Async reset: assert reset=0 mid-REPEAT, at an arbitrary non-clock-edge time:
   - All outputs go to 0 immediately.
   - On deassert with the button still held, a fresh press is accepted after full debounce; the first repeat waits the full RPT_DELAY again.
5. Simultaneous: btn_raw[0] and btn_raw[1] pressed in the same cycle:
   - btn_press[0] and btn_press[1] assert in the same cycle.
   - The repeat streams of both buttons stay aligned.
6. ACTIVE_HIGH=0 build: btn_raw idle=1, pressed=0 -> outputs identical to scenario 1.
